// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared types and constants for the SAR AFE responder
package sar_pkg;

    localparam int DefWidth = 6;
    localparam int CntWidth = 8;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        CONVERT,
        CHECK
    } sar_state_e;

endpackage

// File: rtl/sar_afe_responder_if.sv
// rtl/sar_afe_responder_if.sv - SAR controller <-> analog front-end link
interface sar_afe_responder_if
    import sar_pkg::*;
#(
    parameter int Width = DefWidth
) ();

    logic             sample_i;
    logic [Width-1:0] dac_i;
    logic             eoc_i;
    logic [Width-1:0] result_i;
    logic             cmp_o;

    // master = SAR controller, slave = AFE responder
    modport master (
        output sample_i,
        output dac_i,
        output eoc_i,
        output result_i,
        input  cmp_o
    );

    modport slave (
        input  sample_i,
        input  dac_i,
        input  eoc_i,
        input  result_i,
        output cmp_o
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - increment-enable counter that sticks at all-ones
module sat_counter
    import sar_pkg::*;
#(
    parameter int W = CntWidth
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_o <= '0;
        end else if (inc_i && (count_o != '1)) begin
            count_o <= count_o + W'(1);
        end
    end

endmodule

// File: rtl/sar_afe_responder.sv
// rtl/sar_afe_responder.sv - behavioural AFE: track/hold, offset comparator and conversion checker
module sar_afe_responder
    import sar_pkg::*;
#(
    parameter int Width      = DefWidth,
    parameter int CmpLatency = 0,
    parameter int Timeout    = 2 * Width + 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [Width-1:0]    vin_i,
    input  logic [3:0]          offset_i,
    sar_afe_responder_if.slave  sar,
    output logic                busy_o,
    output logic                done_o,
    output logic                match_o,
    output logic                err_o,
    output logic [CntWidth-1:0] conv_cnt_o,
    output logic [CntWidth-1:0] err_cnt_o
);

    localparam int SumW  = Width + 2;
    localparam int StepW = $clog2(Timeout + 1);

    sar_state_e        state;
    logic [Width-1:0]  vh;
    logic [StepW-1:0]  step;
    logic signed [SumW-1:0] sum_s;
    logic [Width-1:0]  eff;
    logic              raw_cmp;
    logic              hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vh <= '0;
        end else if (sar.sample_i) begin
            vh <= vin_i;
        end
    end

    // Sum is never negative enough to reach the top two bits, so the sign
    // bit flags underflow and bit Width flags overflow past full scale.
    assign sum_s   = $signed({2'b00, vh}) + $signed({{(SumW-4){offset_i[3]}}, offset_i});
    assign eff     = sum_s[SumW-1] ? '0 : (sum_s[Width] ? '1 : sum_s[Width-1:0]);
    assign raw_cmp = (eff >= sar.dac_i);
    assign hit     = (sar.result_i == eff);

    generate
        if (CmpLatency == 0) begin : g_cmp_comb
            assign sar.cmp_o = raw_cmp;
        end else begin : g_cmp_pipe
            logic [CmpLatency-1:0] cmp_pipe;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cmp_pipe <= '0;
                end else begin
                    cmp_pipe[0] <= raw_cmp;
                    for (int i = 1; i < CmpLatency; i++) begin
                        cmp_pipe[i] <= cmp_pipe[i-1];
                    end
                end
            end

            assign sar.cmp_o = cmp_pipe[CmpLatency-1];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            step    <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            match_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            done_o  <= 1'b0;
            match_o <= 1'b0;
            err_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sar.sample_i) begin
                        state  <= TRACK;
                        busy_o <= 1'b1;
                    end
                end
                TRACK: begin
                    if (!sar.sample_i) begin
                        state <= CONVERT;
                        step  <= '0;
                    end
                end
                CONVERT: begin
                    // eoc wins over a simultaneous abort or timeout
                    if (sar.eoc_i) begin
                        state   <= CHECK;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        match_o <= hit;
                        err_o   <= !hit;
                    end else if (sar.sample_i) begin
                        state <= TRACK;
                        err_o <= 1'b1;
                    end else begin
                        step <= step + StepW'(1);
                        if (step == StepW'(Timeout - 1)) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            err_o  <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (sar.sample_i) begin
                        state  <= TRACK;
                        busy_o <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(CntWidth)) u_conv_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (done_o),
        .count_o (conv_cnt_o)
    );

    sat_counter #(.W(CntWidth)) u_err_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (err_o),
        .count_o (err_cnt_o)
    );

endmodule

// File: tb/tb_sar_afe_responder.sv
// tb/tb_sar_afe_responder.sv - directed scoreboard bench for sar_afe_responder
module tb_sar_afe_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] vin;
    logic [3:0] offset;
    logic       busy, done, match, err;
    logic [7:0] conv_cnt, err_cnt;

    int passed = 0;
    int total  = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    sar_afe_responder_if #(.Width(6)) sar ();

    sar_afe_responder #(.Width(6)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .vin_i      (vin),
        .offset_i   (offset),
        .sar        (sar),
        .busy_o     (busy),
        .done_o     (done),
        .match_o    (match),
        .err_o      (err),
        .conv_cnt_o (conv_cnt),
        .err_cnt_o  (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_eff(input int v, input int o);
        int s;
        s = v + o;
        if (s < 0) s = 0;
        if (s > 63) s = 63;
        return s;
    endfunction

    task automatic enter_convert(input int v, input int o);
        vin = v[5:0];
        offset = o[3:0];
        sar.sample_i = 1'b1;
        tick();
        sar.sample_i = 1'b0;
        tick();
    endtask

    task automatic run_sar(output int code);
        code = 0;
        for (int b = 5; b >= 0; b--) begin
            sar.dac_i = 6'(code | (1 << b));
            #1;
            if (sar.cmp_o) code = code | (1 << b);
            tick();
        end
        sar.dac_i = '0;
    endtask

    task automatic check_done(input string tag);
        bit e;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_sb_nonempty"}, (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_match"}, match, e);
            chk({tag, "_err"}, err, !e);
        end
    endtask

    task automatic finish_conv(input string tag, input int res, input bit exp_match);
        sar.result_i = res[5:0];
        sar.eoc_i = 1'b1;
        exp_q.push_back(exp_match);
        tick();
        sar.eoc_i = 1'b0;
        check_done(tag);
        tick();
    endtask

    initial begin
        int code;
        int v, o, e;

        rst_n = 1'b0;
        vin = '0;
        offset = '0;
        sar.sample_i = 1'b0;
        sar.dac_i = '0;
        sar.eoc_i = 1'b0;
        sar.result_i = '0;
        #22;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_match", match, 0);
        chk("rst_err", err, 0);
        chk("rst_conv_cnt", conv_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_cmp", sar.cmp_o, 1);
        rst_n = 1'b1;
        tick();

        // Scenario 1: ideal SAR on vin=45
        enter_convert(45, 0);
        chk("s1_busy", busy, 1);
        run_sar(code);
        chk("s1_code", code, model_eff(45, 0));
        finish_conv("s1", code, 1);
        chk("s1_conv_cnt", conv_cnt, 1);
        chk("s1_err_cnt", err_cnt, 0);

        // Scenario 2: clamping at both ends
        enter_convert(62, 7);
        run_sar(code);
        chk("s2_hi_code", code, 63);
        finish_conv("s2_hi", 63, 1);
        enter_convert(3, -8);
        run_sar(code);
        chk("s2_lo_code", code, 0);
        finish_conv("s2_lo", 0, 1);
        chk("s2_conv_cnt", conv_cnt, 3);

        // Scenario 3: wrong result
        enter_convert(21, 0);
        tick();
        finish_conv("s3", 20, 0);
        chk("s3_err_cnt", err_cnt, 1);
        chk("s3_conv_cnt", conv_cnt, 4);

        // Scenario 4: timeout after 16 CONVERT cycles
        enter_convert(10, 0);
        repeat (15) tick();
        chk("s4_err_early", err, 0);
        chk("s4_busy_early", busy, 1);
        tick();
        chk("s4_err_pulse", err, 1);
        chk("s4_busy_idle", busy, 0);
        tick();
        chk("s4_err_single", err, 0);
        chk("s4_err_cnt", err_cnt, 2);
        chk("s4_conv_cnt", conv_cnt, 4);

        // Scenario 5a: abort by sample_i
        enter_convert(30, 0);
        tick();
        sar.sample_i = 1'b1;
        tick();
        chk("s5a_err", err, 1);
        chk("s5a_busy", busy, 1);
        sar.sample_i = 1'b0;
        tick();
        chk("s5a_err_single", err, 0);
        chk("s5a_err_cnt", err_cnt, 3);

        // Scenario 5b: eoc and sample together -> CHECK, no abort
        sar.sample_i = 1'b1;
        sar.eoc_i = 1'b1;
        sar.result_i = 6'd30;
        exp_q.push_back(1'b1);
        tick();
        sar.eoc_i = 1'b0;
        sar.sample_i = 1'b0;
        check_done("s5b");
        tick();
        chk("s5b_idle", busy, 0);
        chk("s5b_err_cnt", err_cnt, 3);
        chk("s5b_conv_cnt", conv_cnt, 5);

        // Scenario 6: saturation of the conversion counter
        for (int i = 0; i < 300; i++) begin
            v = $urandom_range(0, 63);
            o = int'($urandom_range(0, 15)) - 8;
            e = model_eff(v, o);
            enter_convert(v, o);
            finish_conv("s6_loop", e, 1);
        end
        chk("s6_conv_sat", conv_cnt, 255);
        chk("s6_err_cnt", err_cnt, 3);

        // Reset in the middle of a conversion
        enter_convert(10, 0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_done", done, 0);
        chk("s6_rst_match", match, 0);
        chk("s6_rst_err", err, 0);
        chk("s6_rst_conv_cnt", conv_cnt, 0);
        chk("s6_rst_err_cnt", err_cnt, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("s6_post_err", err, 0);
        chk("s6_post_busy", busy, 0);
        tick();
        chk("s6_post_err_cnt", err_cnt, 0);
        chk("s6_post_conv_cnt", conv_cnt, 0);
        chk("s6_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
